// File: rtl/tdc_readout_pkg.sv
// Shared definitions for the TDC FIFO readout controller.
//   TDC_DATA_WIDTH : width of the TDC chip read bus
//   ADR_FIFO1/2    : chip register addresses of the two result FIFOs
//   state_e        : readout FSM state encoding
package tdc_readout_pkg;

  localparam int TDC_DATA_WIDTH = 28;

  localparam logic [3:0] ADR_FIFO1 = 4'h8;  // channels 0-3
  localparam logic [3:0] ADR_FIFO2 = 4'h9;  // channels 4-7

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEL     = 3'd1,
    ST_RD_LOW  = 3'd2,
    ST_RD_HIGH = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/tdc_flag_sync.sv
// Two-flop synchroniser for an asynchronous, active-high status flag.
// Resets to 1 so an empty flag reads "empty" until the real value arrives.
// Ports:
//   clk     in  clock
//   resetn  in  synchronous active-low reset
//   async_i in  asynchronous flag
//   sync_o  out flag synchronised to clk (two-cycle latency)
module tdc_flag_sync (
  input  logic clk,
  input  logic resetn,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/tdc_fifo_readout_ctrl.sv
// Drains the TDC chip's two result FIFOs after each measurement shot and
// forwards each word as {adr, data} with a one-cycle set strobe; a one-cycle
// save strobe closes every accepted shot, even one with no data.
// Ports:
//   clk, resetn       clock, synchronous active-low reset
//   enable_i          readout allowed
//   shot_done_i       pulse: start draining
//   tdc_ef1_i/ef2_i   async FIFO empty flags (addr 8 / addr 9)
//   tdc_data_i        chip read bus
//   tdc_csn_o/rdn_o   chip select / read strobe, active low
//   tdc_adr_o         chip register address (8 or 9)
//   set_flag_o        pulse: tdc_time_data_o holds a new word
//   tdc_time_data_o   last word read, {adr, data}
//   save_flag_o       pulse: shot complete
//   busy_o            FSM not idle
//   shot_dropped_o    pulse: shot_done_i was ignored
//   word_limit_o      sticky: MAX_WORDS reached in this shot
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for an accepted shot_done_i
// ST_SEL     | chip selected, address settling; decide read / next FIFO / done
// ST_RD_LOW  | read strobe low for RD_LOW_CYC cycles, data captured on last
// ST_RD_HIGH | read strobe high for RD_HIGH_CYC cycles, set_flag in first
// ST_DONE    | chip deselected, save_flag pulse
module tdc_fifo_readout_ctrl
  import tdc_readout_pkg::*;
#(
  parameter int RD_LOW_CYC  = 4,
  parameter int RD_HIGH_CYC = 3,
  parameter int MAX_WORDS   = 16
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      enable_i,
  input  logic                      shot_done_i,
  input  logic                      tdc_ef1_i,
  input  logic                      tdc_ef2_i,
  input  logic [TDC_DATA_WIDTH-1:0] tdc_data_i,
  output logic                      tdc_csn_o,
  output logic                      tdc_rdn_o,
  output logic [3:0]                tdc_adr_o,
  output logic                      set_flag_o,
  output logic [31:0]               tdc_time_data_o,
  output logic                      save_flag_o,
  output logic                      busy_o,
  output logic                      shot_dropped_o,
  output logic                      word_limit_o
);

  localparam logic [7:0] LOW_LOAD  = 8'(RD_LOW_CYC - 1);
  localparam logic [7:0] HIGH_LOAD = 8'(RD_HIGH_CYC - 1);
  localparam logic [7:0] MAX_W     = 8'(MAX_WORDS);

  state_e      state_q, state_d;
  logic        fifo2_q, fifo2_d;        // 0: reading FIFO1, 1: reading FIFO2
  logic [7:0]  cnt_q, cnt_d;            // shared RD_LOW / RD_HIGH down-counter
  logic [7:0]  words_q, words_d;
  logic [31:0] data_q, data_d;
  logic        limit_q, limit_d;
  logic        dropped_q, dropped_d;

  logic ef1_sync, ef2_sync, ef_sel;
  logic shot_accept, cnt_tc;

  tdc_flag_sync u_sync_ef1 (
    .clk     (clk),
    .resetn  (resetn),
    .async_i (tdc_ef1_i),
    .sync_o  (ef1_sync)
  );

  tdc_flag_sync u_sync_ef2 (
    .clk     (clk),
    .resetn  (resetn),
    .async_i (tdc_ef2_i),
    .sync_o  (ef2_sync)
  );

  assign ef_sel      = fifo2_q ? ef2_sync : ef1_sync;
  assign shot_accept = (state_q == ST_IDLE) && shot_done_i && enable_i;
  assign cnt_tc      = (cnt_q == 8'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      fifo2_q   <= 1'b0;
      cnt_q     <= 8'd0;
      words_q   <= 8'd0;
      data_q    <= 32'd0;
      limit_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo2_q   <= fifo2_d;
      cnt_q     <= cnt_d;
      words_q   <= words_d;
      data_q    <= data_d;
      limit_q   <= limit_d;
      dropped_q <= dropped_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (shot_accept) state_d = ST_SEL;
      end
      ST_SEL: begin
        if (ef_sel) begin
          if (fifo2_q) state_d = ST_DONE;
        end else begin
          state_d = ST_RD_LOW;
        end
      end
      ST_RD_LOW: begin
        if (cnt_tc) state_d = ST_RD_HIGH;
      end
      ST_RD_HIGH: begin
        if (cnt_tc) begin
          if ((words_q == MAX_W) || !enable_i) state_d = ST_DONE;
          else                                 state_d = ST_SEL;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    fifo2_d   = fifo2_q;
    cnt_d     = cnt_q;
    words_d   = words_q;
    data_d    = data_q;
    limit_d   = limit_q;
    dropped_d = shot_done_i && !shot_accept;

    unique case (state_q)
      ST_IDLE: begin
        if (shot_accept) begin
          fifo2_d = 1'b0;
          words_d = 8'd0;
          limit_d = 1'b0;
        end
      end
      ST_SEL: begin
        if (ef_sel) begin
          if (!fifo2_q) fifo2_d = 1'b1;
        end else begin
          cnt_d = LOW_LOAD;
        end
      end
      ST_RD_LOW: begin
        if (cnt_tc) begin
          data_d  = {tdc_adr_o, tdc_data_i};
          words_d = words_q + 8'd1;
          cnt_d   = HIGH_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RD_HIGH: begin
        if (!cnt_tc)              cnt_d   = cnt_q - 8'd1;
        else if (words_q == MAX_W) limit_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    tdc_csn_o   = 1'b1;
    tdc_rdn_o   = 1'b1;
    set_flag_o  = 1'b0;
    save_flag_o = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_SEL:     tdc_csn_o = 1'b0;
      ST_RD_LOW: begin
        tdc_csn_o = 1'b0;
        tdc_rdn_o = 1'b0;
      end
      ST_RD_HIGH: begin
        tdc_csn_o  = 1'b0;
        // counter still holds its load value only in the first RD_HIGH cycle
        set_flag_o = (cnt_q == HIGH_LOAD);
      end
      ST_DONE:    save_flag_o = 1'b1;
      default: ;
    endcase
  end

  assign tdc_adr_o       = fifo2_q ? ADR_FIFO2 : ADR_FIFO1;
  assign tdc_time_data_o = data_q;
  assign shot_dropped_o  = dropped_q;
  assign word_limit_o    = limit_q;

endmodule

// File: tb/tb_tdc_fifo_readout_ctrl.sv
module tb_tdc_fifo_readout_ctrl;

  localparam int RD_LOW  = 4;
  localparam int RD_HIGH = 3;
  localparam int MAXW    = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable_i;
  logic        shot_done_i;
  logic        tdc_ef1_i = 1'b1;
  logic        tdc_ef2_i = 1'b1;
  logic [27:0] tdc_data_i = '0;
  logic        tdc_csn_o, tdc_rdn_o;
  logic [3:0]  tdc_adr_o;
  logic        set_flag_o, save_flag_o, busy_o, shot_dropped_o, word_limit_o;
  logic [31:0] tdc_time_data_o;

  tdc_fifo_readout_ctrl #(
    .RD_LOW_CYC (RD_LOW),
    .RD_HIGH_CYC(RD_HIGH),
    .MAX_WORDS  (MAXW)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable_i       (enable_i),
    .shot_done_i    (shot_done_i),
    .tdc_ef1_i      (tdc_ef1_i),
    .tdc_ef2_i      (tdc_ef2_i),
    .tdc_data_i     (tdc_data_i),
    .tdc_csn_o      (tdc_csn_o),
    .tdc_rdn_o      (tdc_rdn_o),
    .tdc_adr_o      (tdc_adr_o),
    .set_flag_o     (set_flag_o),
    .tdc_time_data_o(tdc_time_data_o),
    .save_flag_o    (save_flag_o),
    .busy_o         (busy_o),
    .shot_dropped_o (shot_dropped_o),
    .word_limit_o   (word_limit_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // TDC chip model: two FIFOs, empty flags, bus shows head of addressed FIFO,
  // a word is consumed when the read strobe rises.
  logic [27:0] q1[$];
  logic [27:0] q2[$];
  logic        rdn_prev = 1'b1;

  always @(negedge clk) begin
    if (rdn_prev == 1'b0 && tdc_rdn_o == 1'b1) begin
      if (tdc_adr_o == 4'h9) begin
        if (q2.size() > 0) q2.delete(0);
      end else begin
        if (q1.size() > 0) q1.delete(0);
      end
    end
    rdn_prev   = tdc_rdn_o;
    tdc_ef1_i  = (q1.size() == 0);
    tdc_ef2_i  = (q2.size() == 0);
    if (tdc_adr_o == 4'h9) tdc_data_i = (q2.size() > 0) ? q2[0] : 28'd0;
    else                   tdc_data_i = (q1.size() > 0) ? q1[0] : 28'd0;
  end

  // Expected word stream for the shot: FIFO1 words tagged 8, then FIFO2
  // words tagged 9, cut at MAXW.
  logic [31:0] exp_q[$];
  logic        exp_limit;

  task automatic arm();
    exp_q.delete();
    foreach (q1[i]) if (exp_q.size() < MAXW) exp_q.push_back({4'h8, q1[i]});
    foreach (q2[i]) if (exp_q.size() < MAXW) exp_q.push_back({4'h9, q2[i]});
    exp_limit = ((q1.size() + q2.size()) >= MAXW);
  endtask

  int          cyc = 0;
  int          shot_cyc = 0;
  int          first_set_off = -1;
  int          save_off = -1;
  bit          first_set_seen = 1'b0;
  logic [31:0] first_word = '0;
  int          set_cnt = 0, save_cnt = 0, drop_cnt = 0, busy_cnt = 0;
  int          low_cnt = 0, low_adr8 = 0, low_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process
  always @(negedge clk) begin
    if (!resetn) begin
      low_run = 0;
    end else begin
      if (tdc_rdn_o == 1'b0) begin
        low_run++;
        low_cnt++;
        if (tdc_adr_o == 4'h8) low_adr8++;
        chk("csn_during_read", {31'd0, tdc_csn_o}, 32'd0);
      end else if (low_run > 0) begin
        chk("rdn_low_width", low_run, RD_LOW);
        low_run = 0;
      end
      if (shot_done_i && enable_i && !busy_o) begin
        shot_cyc       = cyc;
        first_set_seen = 1'b0;
      end
      if (busy_o) busy_cnt++;
      if (shot_dropped_o) drop_cnt++;
      if (set_flag_o) begin
        chk("set_save_overlap", {31'd0, save_flag_o}, 32'd0);
        chk("word_overrun", {31'd0, exp_q.size() == 0}, 32'd0);
        if (exp_q.size() > 0) chk("word_data", tdc_time_data_o, exp_q.pop_front());
        if (!first_set_seen) begin
          first_set_seen = 1'b1;
          first_set_off  = cyc - shot_cyc;
          first_word     = tdc_time_data_o;
        end
        set_cnt++;
      end
      if (save_flag_o) begin
        chk("save_words_left", exp_q.size(), 32'd0);
        chk("save_word_limit", {31'd0, word_limit_o}, {31'd0, exp_limit});
        save_off = cyc - shot_cyc;
        save_cnt++;
      end
    end
  end

  task automatic pulse_shot();
    @(posedge clk); #1 shot_done_i = 1'b1;
    @(posedge clk); #1 shot_done_i = 1'b0;
  endtask

  task automatic wait_save(input int s0, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (save_cnt != s0) break;
    end
    chk("save_arrived", save_cnt - s0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int s_set, s_save, s_drop, s_busy, s_low, s_adr8;

  task automatic snap();
    s_set  = set_cnt;
    s_save = save_cnt;
    s_drop = drop_cnt;
    s_busy = busy_cnt;
    s_low  = low_cnt;
    s_adr8 = low_adr8;
  endtask

  initial begin
    resetn      = 1'b0;
    enable_i    = 1'b1;
    shot_done_i = 1'b0;
    exp_limit   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_csn",   {31'd0, tdc_csn_o},      32'd1);
    chk("rst_rdn",   {31'd0, tdc_rdn_o},      32'd1);
    chk("rst_adr",   {28'd0, tdc_adr_o},      32'd8);
    chk("rst_data",  tdc_time_data_o,         32'd0);
    chk("rst_set",   {31'd0, set_flag_o},     32'd0);
    chk("rst_save",  {31'd0, save_flag_o},    32'd0);
    chk("rst_busy",  {31'd0, busy_o},         32'd0);
    chk("rst_limit", {31'd0, word_limit_o},   32'd0);
    chk("rst_drop",  {31'd0, shot_dropped_o}, 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    idle(4);

    // Two words in FIFO1, FIFO2 empty
    q1 = '{28'h4000123, 28'h8000456};
    q2.delete();
    idle(3);
    arm();
    snap();
    pulse_shot();
    wait_save(s_save, 200);
    chk("t1_sets",       set_cnt - s_set, 32'd2);
    chk("t1_first_off",  first_set_off,   32'd6);
    chk("t1_first_word", first_word,      32'h84000123);
    chk("t1_last_word",  tdc_time_data_o, 32'h88000456);
    chk("t1_limit",      {31'd0, word_limit_o}, 32'd0);
    idle(4);

    // Both FIFOs empty
    q1.delete();
    q2.delete();
    idle(3);
    arm();
    snap();
    pulse_shot();
    wait_save(s_save, 50);
    idle(4);
    chk("t2_save_off", save_off,          32'd3);
    chk("t2_busy",     busy_cnt - s_busy, 32'd3);
    chk("t2_no_rdn",   low_cnt - s_low,   32'd0);
    chk("t2_no_set",   set_cnt - s_set,   32'd0);
    chk("t2_one_save", save_cnt - s_save, 32'd1);

    // FIFO1 empty, FIFO2 holds three words
    q1.delete();
    q2 = '{28'h4000010, 28'h4000020, 28'h8000030};
    idle(3);
    arm();
    snap();
    pulse_shot();
    wait_save(s_save, 200);
    chk("t3_sets",       set_cnt - s_set,   32'd3);
    chk("t3_first_word", first_word,        32'h94000010);
    chk("t3_rd_cycles",  low_cnt - s_low,   32'd12);
    chk("t3_no_adr8",    low_adr8 - s_adr8, 32'd0);
    idle(4);

    // FIFOs never run dry: word limit
    q1.delete();
    q2.delete();
    for (int i = 0; i < 20; i++) begin
      q1.push_back(28'h0100000 + 28'(i));
      q2.push_back(28'h0200000 + 28'(i));
    end
    idle(3);
    arm();
    snap();
    pulse_shot();
    wait_save(s_save, 600);
    chk("t4_sets",  set_cnt - s_set,         32'd16);
    chk("t4_limit", {31'd0, word_limit_o},   32'd1);
    idle(4);
    chk("t4_limit_sticky", {31'd0, word_limit_o}, 32'd1);

    // Next shot clears the limit flag
    q1 = '{28'h0000055};
    q2.delete();
    idle(3);
    arm();
    snap();
    pulse_shot();
    chk("t5_limit_cleared", {31'd0, word_limit_o}, 32'd0);
    wait_save(s_save, 200);
    chk("t5_sets", set_cnt - s_set, 32'd1);
    idle(4);

    // shot_done while busy is dropped
    q1 = '{28'h0000011, 28'h0000022};
    q2.delete();
    idle(3);
    arm();
    snap();
    pulse_shot();
    idle(3);
    pulse_shot();
    wait_save(s_save, 200);
    idle(10);
    chk("t6_drop",  drop_cnt - s_drop, 32'd1);
    chk("t6_saves", save_cnt - s_save, 32'd1);
    chk("t6_sets",  set_cnt - s_set,   32'd2);

    // shot_done with enable low is dropped
    enable_i = 1'b0;
    snap();
    pulse_shot();
    idle(10);
    chk("t6b_drop",  drop_cnt - s_drop, 32'd1);
    chk("t6b_saves", save_cnt - s_save, 32'd0);
    chk("t6b_busy",  busy_cnt - s_busy, 32'd0);
    enable_i = 1'b1;
    idle(2);

    // Reset in the middle of a read
    q1 = '{28'h0000101, 28'h0000202, 28'h0000303, 28'h0000404, 28'h0000505};
    q2.delete();
    idle(3);
    arm();
    snap();
    pulse_shot();
    begin
      int k;
      for (k = 0; k < 20; k++) begin
        if (tdc_rdn_o == 1'b0) break;
        @(negedge clk); #1;
      end
      chk("t7_rdn_seen", {31'd0, tdc_rdn_o}, 32'd0);
    end
    @(posedge clk); #1 resetn = 1'b0;
    @(posedge clk); #1;
    chk("t7_csn_after_rst", {31'd0, tdc_csn_o}, 32'd1);
    chk("t7_rdn_after_rst", {31'd0, tdc_rdn_o}, 32'd1);
    chk("t7_busy_after_rst", {31'd0, busy_o},   32'd0);
    idle(2);
    resetn = 1'b1;
    exp_q.delete();
    idle(10);
    chk("t7_no_save", save_cnt - s_save, 32'd0);
    chk("t7_no_set",  set_cnt - s_set,   32'd0);

    // Fresh shot starts from FIFO1
    q1 = '{28'h0000AAA};
    q2.delete();
    idle(3);
    arm();
    snap();
    pulse_shot();
    wait_save(s_save, 200);
    chk("t8_sets",       set_cnt - s_set,   32'd1);
    chk("t8_first_word", first_word,        32'h80000AAA);
    chk("t8_rd_adr8",    low_adr8 - s_adr8, 32'd4);
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
